power_mode_sequencer: RTL and testbench

Upstream controller for the power-setting register stage. Turns operator mode requests into a safe one-hot power select (training 001, dueling 010, bulkhead 100) that drives the power-setting stage's 3-bit input. Enforces stepped power-up, immediate power-down, an arming interlock for bulkhead, and a post-change cooldown.

---
 rtl/power_mode_sequencer_if.sv | 37 +++
 rtl/power_mode_sequencer.sv | 162 ++++++++++++++++
 tb/tb_power_mode_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/power_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : power_mode_sequencer_if
//  Description : Request/response bundle between the operator mode logic and
//                the power mode sequencer (requests, arming key, power select,
//                status flags).
//  Revision    : 1.0 - initial release
// ============================================================================
interface power_mode_sequencer_if;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       arm;
    logic [2:0] pow_sel;
    logic       busy;
    logic       err;

    // Requesting side: issues mode requests and holds the arming key
    modport master (
        output req_valid,
        output req_mode,
        output arm,
        input  pow_sel,
        input  busy,
        input  err
    );

    // Sequencer side
    modport slave (
        input  req_valid,
        input  req_mode,
        input  arm,
        output pow_sel,
        output busy,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/power_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : power_mode_sequencer
//  Description : Converts operator mode requests into a safe one-hot power
//                select (training 001, dueling 010, bulkhead 100). Stepped
//                power-up, immediate power-down, bulkhead arming interlock
//                and a post-change cooldown window.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_mode_sequencer #(
    parameter int STEP_CYCLES = 4,
    parameter int COOLDOWN    = 8,
    parameter int ARM_CYCLES  = 16,
    parameter int CW          = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    power_mode_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_STEADY   = 2'd0,
        S_ARM_WAIT = 2'd1,
        S_RAMP     = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam logic [2:0] c_SEL_TRN = 3'b001;
    localparam logic [2:0] c_SEL_DUE = 3'b010;
    localparam logic [2:0] c_SEL_BLK = 3'b100;

    // Counters run downwards from (N-1); the transition fires on the edge
    // that finds the counter at zero, giving exactly N edges in the phase.
    localparam logic [CW-1:0] c_STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] c_COOL_LOAD = CW'(COOLDOWN - 1);
    localparam logic [CW-1:0] c_ARM_LOAD  = CW'(ARM_CYCLES - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_pow_sel;
    logic            r_busy;
    logic            r_err;

    logic [2:0]      w_req_sel;
    logic            w_abort;
    logic            w_trip;

    // Decode the requested mode into its one-hot select (000 for illegal)
    always_comb begin
        w_req_sel = 3'b000;
        case (bus.req_mode)
            2'd0:    w_req_sel = c_SEL_TRN;
            2'd1:    w_req_sel = c_SEL_DUE;
            2'd2:    w_req_sel = c_SEL_BLK;
            default: w_req_sel = 3'b000;
        endcase
    end

    // Training request while busy is an emergency abort; bulkhead without
    // the key present is an interlock trip. Abort takes precedence.
    assign w_abort = r_busy && bus.req_valid && (bus.req_mode == 2'd0);
    assign w_trip  = (r_pow_sel == c_SEL_BLK) && !bus.arm;

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_STEADY;
            r_cnt     <= '0;
            r_pow_sel <= c_SEL_TRN;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_abort) begin
                r_pow_sel <= c_SEL_TRN;
                r_state   <= S_COOLDOWN;
                r_cnt     <= c_COOL_LOAD;
                r_busy    <= 1'b1;
            end else if (w_trip) begin
                r_pow_sel <= c_SEL_TRN;
                r_state   <= S_COOLDOWN;
                r_cnt     <= c_COOL_LOAD;
                r_busy    <= 1'b1;
                r_err     <= 1'b1;
            end else begin
                case (r_state)
                    S_STEADY: begin
                        if (bus.req_valid) begin
                            if (w_req_sel == 3'b000) begin
                                r_err <= 1'b1;
                            end else if (w_req_sel == r_pow_sel) begin
                                r_state <= S_STEADY;
                            end else if (w_req_sel == c_SEL_BLK) begin
                                r_state <= S_ARM_WAIT;
                                r_cnt   <= c_ARM_LOAD;
                                r_busy  <= 1'b1;
                            end else begin
                                // Downward moves and the single training->dueling
                                // step are applied in one edge
                                r_pow_sel <= w_req_sel;
                                r_state   <= S_COOLDOWN;
                                r_cnt     <= c_COOL_LOAD;
                                r_busy    <= 1'b1;
                            end
                        end
                    end
                    S_ARM_WAIT: begin
                        if (!bus.arm) begin
                            r_err   <= 1'b1;
                            r_state <= S_STEADY;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == '0) begin
                            if (r_pow_sel == c_SEL_TRN) begin
                                r_pow_sel <= c_SEL_DUE;
                                r_state   <= S_RAMP;
                                r_cnt     <= c_STEP_LOAD;
                            end else begin
                                r_pow_sel <= c_SEL_BLK;
                                r_state   <= S_COOLDOWN;
                                r_cnt     <= c_COOL_LOAD;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_RAMP: begin
                        if (r_cnt == '0) begin
                            r_pow_sel <= c_SEL_BLK;
                            r_state   <= S_COOLDOWN;
                            r_cnt     <= c_COOL_LOAD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_COOLDOWN: begin
                        if (r_cnt == '0) begin
                            r_state <= S_STEADY;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_STEADY;
                        r_pow_sel <= c_SEL_TRN;
                        r_busy    <= 1'b0;
                    end
                endcase
                // Any non-abort request arriving while busy is dropped
                if (r_busy && bus.req_valid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.pow_sel = r_pow_sel;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_power_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_power_mode_sequencer
//  Description : Self-checking bench for power_mode_sequencer. Directed
//                scenarios plus random requests, compared every cycle against
//                a timestamp-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_power_mode_sequencer;

    localparam int STEP_CYCLES = 4;
    localparam int COOLDOWN    = 8;
    localparam int ARM_CYCLES  = 16;

    // Model phases
    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_RAMP = 2;
    localparam int P_COOL = 3;

    logic clk;
    logic rst;

    power_mode_sequencer_if bus ();

    power_mode_sequencer #(
        .STEP_CYCLES (STEP_CYCLES),
        .COOLDOWN    (COOLDOWN),
        .ARM_CYCLES  (ARM_CYCLES),
        .CW          (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: level 0/1/2, phase, and the absolute edge number at which the
    // pending phase ends
    int m_edge     = 0;
    int m_level    = 0;
    int m_phase    = P_IDLE;
    int m_deadline = 0;
    int m_err      = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_phase = P_IDLE;
        m_err   = 0;
    endtask

    task automatic model_cool(input int e);
        m_phase    = P_COOL;
        m_deadline = e + COOLDOWN;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] m, input logic a);
        int  e;
        bit  was_busy;
        m_edge++;
        e        = m_edge;
        was_busy = (m_phase != P_IDLE);
        m_err    = 0;
        if (was_busy && v && m == 2'd0) begin
            m_level = 0;
            model_cool(e);
        end else if (m_level == 2 && !a) begin
            m_level = 0;
            m_err   = 1;
            model_cool(e);
        end else begin
            case (m_phase)
                P_IDLE: if (v) begin
                    if (m == 2'd3)             m_err = 1;
                    else if (int'(m) == m_level) m_err = 0;
                    else if (m == 2'd2) begin
                        m_phase    = P_ARM;
                        m_deadline = e + ARM_CYCLES;
                    end else begin
                        m_level = int'(m);
                        model_cool(e);
                    end
                end
                P_ARM: begin
                    if (!a) begin
                        m_err   = 1;
                        m_phase = P_IDLE;
                    end else if (e == m_deadline) begin
                        m_level = m_level + 1;
                        if (m_level == 2) model_cool(e);
                        else begin
                            m_phase    = P_RAMP;
                            m_deadline = e + STEP_CYCLES;
                        end
                    end
                end
                P_RAMP: if (e == m_deadline) begin
                    m_level = 2;
                    model_cool(e);
                end
                default: if (e == m_deadline) m_phase = P_IDLE;
            endcase
            if (was_busy && v) m_err = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".pow_sel"}, int'(bus.pow_sel), 1 << m_level);
        check_eq({tag, ".busy"},    int'(bus.busy),    (m_phase != P_IDLE) ? 1 : 0);
        check_eq({tag, ".err"},     int'(bus.err),     m_err);
    endtask

    // One clock: drive inputs away from the edge, model the edge, check after
    task automatic step(input logic v, input logic [1:0] m, input logic a);
        bus.req_valid = v;
        bus.req_mode  = m;
        bus.arm       = a;
        @(posedge clk);
        model_edge(v, m, a);
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset asserted between edges, checked before next edge
    task automatic do_reset(input int n);
        #2;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        repeat (n) begin
            @(posedge clk);
            #1;
            check_outputs("in_rst");
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle_until_free(input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            step(1'b0, 2'd0, 1'b1);
            k++;
        end
        if (bus.busy) check_eq("busy_timeout", 1, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_mode  = 2'd0;
        bus.arm       = 1'b1;

        // Reset then quiet period
        do_reset(3);
        repeat (5) step(1'b0, 2'd0, 1'b1);

        // Training -> dueling
        step(1'b1, 2'd1, 1'b1);
        check_eq("t2d.sel", int'(bus.pow_sel), 2);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 2'd0, 1'b1);
            if (k == 7) check_eq("t2d.busy_hi", int'(bus.busy), 1);
            if (k == 8) check_eq("t2d.busy_lo", int'(bus.busy), 0);
        end

        // Back down to training, then training -> bulkhead timeline
        step(1'b1, 2'd0, 1'b1);
        idle_until_free(20);
        step(1'b1, 2'd2, 1'b1);
        for (int k = 1; k <= 28; k++) begin
            step(1'b0, 2'd0, 1'b1);
            if (k == 15) check_eq("t2b.hold", int'(bus.pow_sel), 1);
            if (k == 16) check_eq("t2b.due",  int'(bus.pow_sel), 2);
            if (k == 19) check_eq("t2b.due2", int'(bus.pow_sel), 2);
            if (k == 20) check_eq("t2b.blk",  int'(bus.pow_sel), 4);
            if (k == 27) check_eq("t2b.busy_hi", int'(bus.busy), 1);
            if (k == 28) check_eq("t2b.busy_lo", int'(bus.busy), 0);
        end

        // Interlock trip in bulkhead steady
        step(1'b0, 2'd0, 1'b0);
        check_eq("trip.sel", int'(bus.pow_sel), 1);
        check_eq("trip.err", int'(bus.err), 1);
        idle_until_free(20);

        // Arm drop during arm wait
        step(1'b1, 2'd2, 1'b1);
        repeat (5) step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b0);
        check_eq("armdrop.err",  int'(bus.err), 1);
        check_eq("armdrop.busy", int'(bus.busy), 0);

        // Busy rejection then abort during the dueling ramp step
        step(1'b1, 2'd2, 1'b1);
        repeat (17) step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd2, 1'b1);
        check_eq("rej.err", int'(bus.err), 1);
        step(1'b1, 2'd0, 1'b1);
        check_eq("abort.sel", int'(bus.pow_sel), 1);
        check_eq("abort.err", int'(bus.err), 0);
        idle_until_free(20);

        // Illegal request
        step(1'b1, 2'd3, 1'b1);
        check_eq("illegal.err", int'(bus.err), 1);
        step(1'b0, 2'd0, 1'b1);

        // Async reset mid-ramp
        step(1'b1, 2'd2, 1'b1);
        repeat (18) step(1'b0, 2'd0, 1'b1);
        do_reset(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic       v;
            logic [1:0] m;
            logic       a;
            v = ($urandom_range(0, 99) < 15);
            m = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 999) < 985);
            step(v, m, a);
            if (i == 2000) do_reset(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
